load_store_unit: RTL and testbench

//  Memory-access stage feeding the register file write port in the RV32I core.

---
 rtl/load_store_unit.sv | 137 +++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store stage: word bus access with byte strobes and load write-back
module load_store_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] store_data,
   input  logic [4:0]        rd_in,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              wb_en,
   output logic [4:0]        wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              misaligned
);

   typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

   state_t              state, state_next;
   logic                op_store;
   logic [2:0]          op_f3;
   logic [ADDR_W-1:0]   op_addr;
   logic [DATA_W-1:0]   op_sd;
   logic [DATA_W-1:0]   op_rdata;
   logic [4:0]          op_rd;
   logic                illegal;
   logic [1:0]          off;
   logic [DATA_W-1:0]   shifted;

   // Legality is judged on the live inputs so IDLE can branch straight to ERR.
   always_comb begin
      illegal = 1'b0;
      if (is_store) begin
         if (funct3 > 3'd2) illegal = 1'b1;
      end else if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) begin
         illegal = 1'b1;
      end
      if (funct3[1:0] == 2'd1 && addr[0]) illegal = 1'b1;
      if (funct3[1:0] == 2'd2 && addr[1:0] != 2'b00) illegal = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         op_store <= 1'b0;
         op_f3    <= 3'd0;
         op_addr  <= '0;
         op_sd    <= '0;
         op_rdata <= '0;
         op_rd    <= 5'd0;
      end else begin
         state <= state_next;
         if (state == IDLE && start) begin
            op_store <= is_store;
            op_f3    <= funct3;
            op_addr  <= addr;
            op_sd    <= store_data;
            op_rd    <= rd_in;
         end
         if (state == REQ && mem_ready && !op_store) op_rdata <= mem_rdata;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = illegal ? ERR : REQ;
         REQ:     if (mem_ready) state_next = DONE;
         DONE:    state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign off     = op_addr[1:0];
   assign shifted = op_rdata >> {off, 3'b000};

   // Bus-side outputs are forced to zero whenever no request is outstanding.
   always_comb begin
      mem_req   = (state == REQ);
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wstrb = 4'b0000;
      mem_wdata = '0;
      if (mem_req) begin
         mem_we   = op_store;
         mem_addr = {op_addr[ADDR_W-1:2], 2'b00};
         if (op_store) begin
            case (op_f3[1:0])
               2'd0: begin
                  mem_wstrb = 4'b0001 << off;
                  mem_wdata = {4{op_sd[7:0]}};
               end
               2'd1: begin
                  mem_wstrb = 4'b0011 << off;
                  mem_wdata = {2{op_sd[15:0]}};
               end
               default: begin
                  mem_wstrb = 4'b1111;
                  mem_wdata = op_sd;
               end
            endcase
         end
      end
   end

   always_comb begin
      wb_en   = (state == DONE) && !op_store && (op_rd != 5'd0);
      wb_rd   = 5'd0;
      wb_data = '0;
      if (wb_en) begin
         wb_rd = op_rd;
         case (op_f3)
            3'd0:    wb_data = {{24{shifted[7]}}, shifted[7:0]};
            3'd4:    wb_data = {24'd0, shifted[7:0]};
            3'd1:    wb_data = {{16{shifted[15]}}, shifted[15:0]};
            3'd5:    wb_data = {16'd0, shifted[15:0]};
            default: wb_data = shifted;
         endcase
      end
   end

   assign misaligned = (state == ERR);
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [4:0]  rd_in;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        misaligned;

   int n_cmp = 0;
   int n_bad = 0;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
      .addr(addr), .store_data(store_data), .rd_in(rd_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .busy(busy), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issues a one-cycle start in cycle 0; returns positioned in cycle 1.
   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] rd);
      is_store = st; funct3 = f3; addr = a; store_data = sd; rd_in = rd; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      n_cmp++;
      if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, busy, wb_en, wb_rd, wb_data, misaligned} !== 79'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got req=%0b busy=%0b wb_en=%0b mis=%0b, want all 0", mem_req, busy, wb_en, misaligned);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rdata, input logic [4:0] rd,
                            input logic [31:0] exp_addr, input logic [31:0] exp_data);
      issue(1'b0, f3, a, 32'hFFFF_FFFF, rd);
      n_cmp++;
      if ({mem_req, mem_we, mem_wstrb, mem_addr, busy, wb_en} !== {1'b1, 1'b0, 4'h0, exp_addr, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL %s_req: got req=%0b we=%0b strb=%h addr=%h busy=%0b, want req=1 we=0 strb=0 addr=%h busy=1",
                  name, mem_req, mem_we, mem_wstrb, mem_addr, busy, exp_addr);
      end
      mem_ready = 1'b1; mem_rdata = rdata;
      tick();
      mem_ready = 1'b0; mem_rdata = 32'h0;
      n_cmp++;
      if ({wb_en, wb_rd, wb_data, busy, mem_req} !== {(rd != 5'd0), (rd != 5'd0) ? rd : 5'd0,
                                                      (rd != 5'd0) ? exp_data : 32'd0, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL %s_wb: got wb_en=%0b rd=%0d data=%h busy=%0b, want rd=%0d data=%h busy=1",
                  name, wb_en, wb_rd, wb_data, busy, rd, exp_data);
      end
      tick();
      n_cmp++;
      if ({busy, wb_en, wb_rd, wb_data} !== 39'd0) begin
         n_bad++;
         $display("FAIL %s_idle: got busy=%0b wb_en=%0b rd=%0d data=%h, want all 0", name, busy, wb_en, wb_rd, wb_data);
      end
   endtask

   task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input logic [31:0] exp_addr,
                             input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
      issue(1'b1, f3, a, sd, 5'd9);
      n_cmp++;
      if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 1'b1, exp_addr, exp_strb, exp_wdata}) begin
         n_bad++;
         $display("FAIL %s_req: got req=%0b we=%0b addr=%h strb=%b wdata=%h, want 1 1 %h %b %h",
                  name, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, exp_addr, exp_strb, exp_wdata);
      end
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      n_cmp++;
      if ({wb_en, busy, mem_req, mem_we, mem_wstrb} !== {1'b0, 1'b1, 1'b0, 1'b0, 4'h0}) begin
         n_bad++;
         $display("FAIL %s_done: got wb_en=%0b busy=%0b req=%0b we=%0b strb=%b, want 0 1 0 0 0000",
                  name, wb_en, busy, mem_req, mem_we, mem_wstrb);
      end
      tick();
      n_cmp++;
      if ({busy, wb_en} !== 2'b00) begin
         n_bad++;
         $display("FAIL %s_idle: got busy=%0b wb_en=%0b, want 0 0", name, busy, wb_en);
      end
   endtask

   task automatic test_illegal(input string name, input logic st, input logic [2:0] f3, input logic [31:0] a);
      issue(st, f3, a, 32'h1234_5678, 5'd3);
      n_cmp++;
      if ({misaligned, busy, mem_req, wb_en} !== 4'b1100) begin
         n_bad++;
         $display("FAIL %s_err: got mis=%0b busy=%0b req=%0b wb_en=%0b, want 1 1 0 0", name, misaligned, busy, mem_req, wb_en);
      end
      tick();
      n_cmp++;
      if ({misaligned, busy, mem_req, wb_en} !== 4'b0000) begin
         n_bad++;
         $display("FAIL %s_after: got mis=%0b busy=%0b req=%0b wb_en=%0b, want all 0", name, misaligned, busy, mem_req, wb_en);
      end
   endtask

   task automatic test_back_to_back_wait;
      issue(1'b1, 3'd2, 32'h0000_3004, 32'hDEAD_BEEF, 5'd0);
      for (int c = 1; c <= 4; c++) begin
         n_cmp++;
         if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, busy} !== {1'b1, 1'b1, 32'h3004, 4'hF, 32'hDEAD_BEEF, 1'b1}) begin
            n_bad++;
            $display("FAIL sw_wait_c%0d: got req=%0b we=%0b addr=%h strb=%b wdata=%h busy=%0b, want 1 1 00003004 1111 deadbeef 1",
                     c, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, busy);
         end
         if (c == 2) begin
            is_store = 1'b0; funct3 = 3'd2; addr = 32'h5000; rd_in = 5'd4; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         mem_ready = (c == 4);
         tick();
      end
      mem_ready = 1'b0;
      n_cmp++;
      if ({busy, wb_en, mem_req} !== 3'b100) begin
         n_bad++;
         $display("FAIL sw_wait_done: got busy=%0b wb_en=%0b req=%0b, want 1 0 0", busy, wb_en, mem_req);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if ({busy, mem_req, wb_en, misaligned} !== 4'b0000) begin
            n_bad++;
            $display("FAIL sw_wait_idle%0d: got busy=%0b req=%0b wb_en=%0b mis=%0b, want all 0", c, busy, mem_req, wb_en, misaligned);
         end
      end
   endtask

   task automatic test_reset_in_req;
      issue(1'b0, 3'd2, 32'h0000_1000, 32'h0, 5'd7);
      n_cmp++;
      if (mem_req !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_req_pre: got req=%0b, want 1", mem_req);
      end
      rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
      tick();
      rst = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
      n_cmp++;
      if ({mem_req, busy, wb_en, misaligned} !== 4'b0000) begin
         n_bad++;
         $display("FAIL rst_req_post: got req=%0b busy=%0b wb_en=%0b mis=%0b, want all 0", mem_req, busy, wb_en, misaligned);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if ({mem_req, busy, wb_en, misaligned} !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_req_follow%0d: got req=%0b busy=%0b wb_en=%0b mis=%0b, want all 0", c, mem_req, busy, wb_en, misaligned);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'h0;
      store_data = 32'h0; rd_in = 5'd0; mem_ready = 1'b0; mem_rdata = 32'h0;
      test_reset();
      test_load("lb",  3'd0, 32'h0000_1003, 32'h8012_3456, 5'd5,  32'h1000, 32'hFFFF_FF80);
      test_load("lbu", 3'd4, 32'h0000_1003, 32'h8012_3456, 5'd5,  32'h1000, 32'h0000_0080);
      test_load("lhu", 3'd5, 32'h0000_1002, 32'hBEEF_0000, 5'd12, 32'h1000, 32'h0000_BEEF);
      test_load("lh",  3'd1, 32'h0000_1002, 32'hBEEF_0000, 5'd31, 32'h1000, 32'hFFFF_BEEF);
      test_load("lb0", 3'd0, 32'h0000_1000, 32'h0000_007F, 5'd1,  32'h1000, 32'h0000_007F);
      test_load("lw",  3'd2, 32'h0000_2008, 32'h1234_5678, 5'd2,  32'h2008, 32'h1234_5678);
      test_load("lw_x0", 3'd2, 32'h0000_2008, 32'h1234_5678, 5'd0, 32'h2008, 32'h1234_5678);
      test_store("sh", 3'd1, 32'h0000_2002, 32'hABCD_1234, 32'h2000, 4'b1100, 32'h1234_1234);
      test_store("sb", 3'd0, 32'h0000_2001, 32'h0000_00EF, 32'h2000, 4'b0010, 32'hEFEF_EFEF);
      test_store("sw", 3'd2, 32'h0000_2004, 32'h0102_0304, 32'h2004, 4'b1111, 32'h0102_0304);
      test_illegal("lw_mis", 1'b0, 3'd2, 32'h0000_1001);
      test_illegal("lh_mis", 1'b0, 3'd1, 32'h0000_1003);
      test_illegal("ld_f3",  1'b0, 3'd3, 32'h0000_1000);
      test_illegal("st_f3",  1'b1, 3'd4, 32'h0000_1000);
      test_back_to_back_wait();
      test_reset_in_req();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
